// File: rtl/modexp_pkg.sv
// Shared constants for the square-and-multiply modular exponentiation controller.
package modexp_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_EXP_WIDTH = 16;
  localparam int PROD_WIDTH    = 2 * DEF_WIDTH;

  // Cycles the shared reducer takes from start pulse to completion pulse in benches.
  localparam int RED_LATENCY = 15;

  localparam int STATE_W = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_BASE_RED  = 4'd1;
  localparam logic [3:0] ST_SQ_MUL    = 4'd2;
  localparam logic [3:0] ST_SQ_ISSUE  = 4'd3;
  localparam logic [3:0] ST_SQ_WAIT   = 4'd4;
  localparam logic [3:0] ST_MUL_MUL   = 4'd5;
  localparam logic [3:0] ST_MUL_ISSUE = 4'd6;
  localparam logic [3:0] ST_MUL_WAIT  = 4'd7;
  localparam logic [3:0] ST_NEXT      = 4'd8;
  localparam logic [3:0] ST_DONE      = 4'd9;

endpackage

// File: rtl/modexp_mul.sv
// Registered WIDTH x WIDTH multiplier; the full-width product appears one cycle after the operands.
module modexp_mul
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] p_out
);

  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] p_q;

  always_comb begin
    p_d = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_out = p_q;

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod modulus
// with an internal multiplier and an external shared reducer.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ready_in,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     modulus_in,
  output logic [WIDTH-1:0]     value_out,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 err_out,
  output logic                 red_ready_out,
  output logic [2*WIDTH-1:0]   red_value_out,
  output logic [2*WIDTH-1:0]   red_modulus_out,
  input  logic [2*WIDTH-1:0]   red_value_in,
  input  logic                 red_valid_in
);

  localparam int PW    = 2 * WIDTH;
  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     base_red_q, base_red_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 busy_q, busy_d;
  logic                 busy_prev_q, busy_prev_d;
  logic                 err_q, err_d;
  logic                 red_ready_q, red_ready_d;
  logic [PW-1:0]        red_value_q, red_value_d;

  logic [WIDTH-1:0]     mul_b;
  logic [PW-1:0]        mul_p;
  logic                 red_hi_unused;

  modexp_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a_in   (acc_q),
    .b_in   (mul_b),
    .p_out  (mul_p)
  );

  // Reducer handshake: red_ready_out pulses one cycle with red_value_out valid;
  // red_value_out then holds until red_valid_in pulses. At most one reduction
  // is in flight, and red_valid_in is only honoured in the matching wait state.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    mod_d       = mod_q;
    base_red_d  = base_red_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    value_d     = value_q;
    busy_d      = busy_q;
    busy_prev_d = busy_q;
    err_d       = err_q;
    red_ready_d = 1'b0;
    red_value_d = red_value_q;
    mul_b       = (state_q == ST_MUL_MUL) ? base_red_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (ready_in) begin
          exp_d  = exp_in;
          mod_d  = modulus_in;
          busy_d = 1'b1;
          err_d  = 1'b0;
          idx_d  = IDX_TOP;
          acc_d  = '0;
          // Moduli 0 and 1 have a fixed answer of 0, so no reduction is needed.
          if (modulus_in <= WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_BASE_RED;
            red_ready_d = 1'b1;
            red_value_d = {{WIDTH{1'b0}}, base_in};
          end
        end
      end
      ST_BASE_RED: begin
        if (red_valid_in) begin
          base_red_d = red_value_in[WIDTH-1:0];
          acc_d      = WIDTH'(1);
          state_d    = ST_SQ_MUL;
        end
      end
      ST_SQ_MUL:   state_d = ST_SQ_ISSUE;
      ST_SQ_ISSUE: begin
        red_ready_d = 1'b1;
        red_value_d = mul_p;
        state_d     = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (red_valid_in) begin
          acc_d   = red_value_in[WIDTH-1:0];
          state_d = exp_q[idx_q] ? ST_MUL_MUL : ST_NEXT;
        end
      end
      ST_MUL_MUL:   state_d = ST_MUL_ISSUE;
      ST_MUL_ISSUE: begin
        red_ready_d = 1'b1;
        red_value_d = mul_p;
        state_d     = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (red_valid_in) begin
          acc_d   = red_value_in[WIDTH-1:0];
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SQ_MUL;
        end
      end
      ST_DONE: begin
        value_d = acc_q;
        busy_d  = 1'b0;
        err_d   = (mod_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      mod_q       <= '0;
      base_red_q  <= '0;
      acc_q       <= '0;
      idx_q       <= IDX_TOP;
      value_q     <= '0;
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      err_q       <= 1'b0;
      red_ready_q <= 1'b0;
      red_value_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      mod_q       <= mod_d;
      base_red_q  <= base_red_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      value_q     <= value_d;
      busy_q      <= busy_d;
      busy_prev_q <= busy_prev_d;
      err_q       <= err_d;
      red_ready_q <= red_ready_d;
      red_value_q <= red_value_d;
    end
  end

  assign value_out       = value_q;
  assign busy_out        = busy_q;
  assign valid_out       = busy_prev_q & ~busy_q;
  assign err_out         = err_q;
  assign red_ready_out   = red_ready_q;
  assign red_value_out   = red_value_q;
  assign red_modulus_out = {{WIDTH{1'b0}}, mod_q};
  assign red_hi_unused   = ^red_value_in[PW-1:WIDTH];

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: behavioural reducer, arithmetic result model and directed runs.
`timescale 1ns/1ps
module tb_modexp_ctrl;
  import modexp_pkg::*;

  localparam int W     = 16;
  localparam int EW    = 16;
  localparam int PW    = 2 * W;
  localparam int ENT_W = 8 + 1 + W;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            ready_in;
  logic [W-1:0]    base_in;
  logic [EW-1:0]   exp_in;
  logic [W-1:0]    modulus_in;
  logic [W-1:0]    value_out;
  logic            busy_out;
  logic            valid_out;
  logic            err_out;
  logic            red_ready_out;
  logic [PW-1:0]   red_value_out;
  logic [PW-1:0]   red_modulus_out;
  logic [PW-1:0]   red_value_in;
  logic            red_valid_in;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ready_in        (ready_in),
    .base_in         (base_in),
    .exp_in          (exp_in),
    .modulus_in      (modulus_in),
    .value_out       (value_out),
    .busy_out        (busy_out),
    .valid_out       (valid_out),
    .err_out         (err_out),
    .red_ready_out   (red_ready_out),
    .red_value_out   (red_value_out),
    .red_modulus_out (red_modulus_out),
    .red_value_in    (red_value_in),
    .red_valid_in    (red_valid_in)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ENT_W-1:0] exp_q[$];   // {reductions[7:0], err, value[W-1:0]}
  int red_count = 0;
  int red_total = 0;
  int done_cnt  = 0;
  logic busy_prev = 1'b0;
  logic outstanding = 1'b0;
  logic [PW-1:0] held_val = '0;
  logic [W-1:0] cur_mod = '0;
  logic [PW-1:0] red_v, red_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Right-to-left binary exponentiation on plain integers.
  function automatic logic [ENT_W-1:0] model(input logic [W-1:0] b, input logic [EW-1:0] e,
                                             input logic [W-1:0] m);
    longint unsigned r, bb, mm;
    logic [EW-1:0] ee;
    logic [7:0] n;
    if (m == '0) return {8'd0, 1'b1, W'(0)};
    if (m == W'(1)) return {8'd0, 1'b0, W'(0)};
    mm = longint'(m);
    bb = longint'(b) % mm;
    r  = 1;
    ee = e;
    while (ee != '0) begin
      if (ee[0]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
      ee = ee >> 1;
    end
    n = 8'(1 + EW + $countones(e));
    return {n, 1'b0, W'(r)};
  endfunction

  // ---------------- behavioural reducer ----------------
  initial begin
    red_valid_in = 1'b0;
    red_value_in = '0;
    forever begin
      @(negedge clk_in);
      if (red_ready_out === 1'b1) begin
        red_v = red_value_out;
        red_m = red_modulus_out;
        repeat (RED_LATENCY) @(posedge clk_in);
        #1;
        red_value_in = (red_m == '0) ? '0 : red_v % red_m;
        red_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        red_valid_in = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [ENT_W-1:0] e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        exp_q.delete();
        outstanding = 1'b0;
        red_count   = 0;
        busy_prev   = 1'b0;
      end else begin
        check("valid_pulse", 64'(valid_out), 64'(busy_prev & ~busy_out));
        if (outstanding) begin
          check("red_no_overlap", 64'(red_ready_out), 64'd0);
          check("red_value_stable", 64'(red_value_out), 64'(held_val));
          if (red_valid_in) outstanding = 1'b0;
        end else if (red_ready_out) begin
          red_count++;
          red_total++;
          outstanding = 1'b1;
          held_val    = red_value_out;
          check("red_modulus", 64'(red_modulus_out), 64'({W'(0), cur_mod}));
        end
        if (valid_out) begin
          check("result_pending", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("value", 64'(value_out), 64'(e[W-1:0]));
            check("err", 64'(err_out), 64'(e[W]));
            check("reductions", 64'(red_count), 64'(e[ENT_W-1:W+1]));
          end
          red_count = 0;
          done_cnt++;
        end
        busy_prev = busy_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    @(posedge clk_in);
    #1;
    base_in    = b;
    exp_in     = e;
    modulus_in = m;
    ready_in   = 1'b1;
    cur_mod    = m;
    exp_q.push_back(model(b, e, m));
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    int start;
    start  = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < budget) begin
      @(negedge clk_in);
      #1;
      cycles++;
    end
    check("done_in_budget", 64'(done_cnt != start), 64'd1);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_value"}, 64'(value_out), 64'd0);
    check({pfx, "_busy"}, 64'(busy_out), 64'd0);
    check({pfx, "_valid"}, 64'(valid_out), 64'd0);
    check({pfx, "_err"}, 64'(err_out), 64'd0);
    check({pfx, "_red_ready"}, 64'(red_ready_out), 64'd0);
    check({pfx, "_red_value"}, 64'(red_value_out), 64'd0);
    check({pfx, "_red_modulus"}, 64'(red_modulus_out), 64'd0);
    check({pfx, "_state"}, 64'(dut.state_q), 64'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int tot0;
    logic [ENT_W-1:0] m;

    rst_in     = 1'b1;
    ready_in   = 1'b0;
    base_in    = '0;
    exp_in     = '0;
    modulus_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_idle("reset");
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Hand-computed values pin the model.
    m = model(16'd4, 16'd13, 16'd497);
    check("model_4_13_497", 64'(m[W-1:0]), 64'd445);
    check("model_nred_13", 64'(m[ENT_W-1:W+1]), 64'd20);
    m = model(16'd3, 16'd0, 16'd7);
    check("model_exp0", 64'(m[W-1:0]), 64'd1);
    m = model(16'd3, 16'd200, 16'd1000);
    check("model_3_200_1000", 64'(m[W-1:0]), 64'd1);

    tot0 = red_total;
    start_op(16'd4, 16'd13, 16'd497);
    wait_done(2000, cyc);
    check("run_445_value", 64'(value_out), 64'd445);
    check("run_445_err", 64'(err_out), 64'd0);
    check("run_445_nred", 64'(red_total - tot0), 64'd20);

    tot0 = red_total;
    start_op(16'd3, 16'd0, 16'd7);
    wait_done(2000, cyc);
    check("run_exp0_value", 64'(value_out), 64'd1);
    check("run_exp0_nred", 64'(red_total - tot0), 64'd17);

    start_op(16'd10, 16'd1, 16'd7);
    wait_done(2000, cyc);
    check("run_10_1_7", 64'(value_out), 64'd3);

    start_op(16'd3, 16'd200, 16'd1000);
    wait_done(2000, cyc);
    check("run_3_200_1000", 64'(value_out), 64'd1);

    start_op(16'hffff, 16'hffff, 16'hfffe);
    wait_done(2000, cyc);

    tot0 = red_total;
    start_op(16'd123, 16'd456, 16'd1);
    wait_done(10, cyc);
    check("mod1_fast", 64'(cyc <= 3), 64'd1);
    check("mod1_value", 64'(value_out), 64'd0);
    check("mod1_no_red", 64'(red_total - tot0), 64'd0);

    start_op(16'd5, 16'd5, 16'd0);
    wait_done(10, cyc);
    check("mod0_value", 64'(value_out), 64'd0);
    check("mod0_err", 64'(err_out), 64'd1);

    start_op(16'd6, 16'd2, 16'd11);
    @(negedge clk_in);
    check("err_cleared_on_accept", 64'(err_out), 64'd0);
    wait_done(2000, cyc);
    check("run_6_2_11", 64'(value_out), 64'd3);

    // ready_in held high through a whole run with other operands.
    @(posedge clk_in);
    #1;
    base_in = 16'd10; exp_in = 16'd1; modulus_in = 16'd7; ready_in = 1'b1; cur_mod = 16'd7;
    exp_q.push_back(model(16'd10, 16'd1, 16'd7));
    exp_q.push_back(model(16'd3, 16'd200, 16'd1000));
    @(posedge clk_in);
    #1;
    base_in = 16'd3; exp_in = 16'd200; modulus_in = 16'd1000;
    cyc = 0;
    while (!valid_out && cyc < 2000) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    check("hold_first_done", 64'(valid_out), 64'd1);
    check("hold_first_value", 64'(value_out), 64'd3);
    cur_mod = 16'd1000;
    @(posedge clk_in);
    #1 ready_in = 1'b0;
    @(negedge clk_in);
    check("hold_accept_after_valid", 64'(busy_out), 64'd1);
    wait_done(2000, cyc);
    check("hold_second_value", 64'(value_out), 64'd1);

    // Reset while the controller waits on a square reduction.
    start_op(16'd4, 16'd13, 16'd497);
    tot0 = red_total;
    cyc  = 0;
    while (red_total < tot0 + 2 && cyc < 2000) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    check("reached_sq_wait", 64'(red_total >= tot0 + 2), 64'd1);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_idle("abort");
    tot0 = red_total;
    repeat (40) begin
      @(negedge clk_in);
      check("abort_quiet_busy", 64'(busy_out), 64'd0);
    end
    check("abort_no_red", 64'(red_total - tot0), 64'd0);

    start_op(16'd4, 16'd13, 16'd497);
    wait_done(2000, cyc);
    check("after_abort_value", 64'(value_out), 64'd445);

    repeat (5) @(posedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
